// File: rtl/alu_exec_if.sv
// Issue bundle from the reservation station and the result broadcast snooped by RS/LSB/ROB.
// The master drives issue and watches results; the slave is the execute unit.
interface alu_exec_if #(
    parameter int OP_W      = 6,
    parameter int ROB_POS_W = 5,
    parameter int DATA_W    = 32
);
    logic                 alu_enable;
    logic [OP_W-1:0]      alu_openum;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic [DATA_W-1:0]    alu_rs1_val;
    logic [DATA_W-1:0]    alu_rs2_val;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_pc;

    logic                 alu_result_ready;
    logic [ROB_POS_W-1:0] alu_result_rob_pos;
    logic [DATA_W-1:0]    alu_result_val;
    logic                 alu_result_jump;
    logic [DATA_W-1:0]    alu_result_pc;

    modport master (
        output alu_enable, alu_openum, alu_rob_pos, alu_rs1_val, alu_rs2_val, alu_imm, alu_pc,
        input  alu_result_ready, alu_result_rob_pos, alu_result_val, alu_result_jump, alu_result_pc
    );

    modport slave (
        input  alu_enable, alu_openum, alu_rob_pos, alu_rs1_val, alu_rs2_val, alu_imm, alu_pc,
        output alu_result_ready, alu_result_rob_pos, alu_result_val, alu_result_jump, alu_result_pc
    );
endinterface

// File: rtl/alu_exec.sv
// Two-stage RV32I execute unit; an op issued in cycle N is broadcast in cycle N+2.
// No backpressure: every enabled op is accepted; rdy=0 freezes stages, outputs and counters.
module alu_exec #(
    parameter int OP_W      = 6,
    parameter int ROB_POS_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    alu_exec_if.slave   alu,
    output logic [31:0] op_count,
    output logic [31:0] jump_count
);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

    logic                 s1_vld;
    logic [OP_W-1:0]      s1_op;
    logic [ROB_POS_W-1:0] s1_rob;
    logic [DATA_W-1:0]    s1_pc, s1_a, s1_b, s1_imm;

    logic                 s2_vld;
    logic [ROB_POS_W-1:0] s2_rob;
    logic [DATA_W-1:0]    s2_val, s2_pc;
    logic                 s2_jump;

    logic                 b_is_imm;
    logic [DATA_W-1:0]    sum, pc4, br_target;
    logic                 lt_s, lt_u, eq;
    logic [DATA_W-1:0]    nxt_val, nxt_pc;
    logic                 nxt_jump, br_taken, is_branch;

    // Operand B selection happens at issue so stage 2 only sees A/B/imm.
    always_comb begin
        b_is_imm = 1'b0;
        case (alu.alu_openum)
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
            OP_SLLI, OP_SRLI, OP_SRAI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: b_is_imm = 1'b1;
            default: b_is_imm = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            s1_vld <= 1'b0;
        end else if (rdy) begin
            s1_vld <= alu.alu_enable;
            s1_op  <= alu.alu_openum;
            s1_rob <= alu.alu_rob_pos;
            s1_pc  <= alu.alu_pc;
            s1_a   <= alu.alu_rs1_val;
            s1_b   <= b_is_imm ? alu.alu_imm : alu.alu_rs2_val;
            s1_imm <= alu.alu_imm;
        end
    end

    assign sum       = s1_a + s1_b;
    assign pc4       = s1_pc + DATA_W'(4);
    assign br_target = s1_pc + s1_imm;
    assign lt_s      = $signed(s1_a) < $signed(s1_b);
    assign lt_u      = s1_a < s1_b;
    assign eq        = s1_a == s1_b;

    always_comb begin
        nxt_val   = '0;
        nxt_jump  = 1'b0;
        nxt_pc    = pc4;
        br_taken  = 1'b0;
        is_branch = 1'b0;
        case (s1_op)
            OP_ADD, OP_ADDI:   nxt_val = sum;
            OP_SUB:            nxt_val = s1_a - s1_b;
            OP_SLL, OP_SLLI:   nxt_val = s1_a << s1_b[4:0];
            OP_SRL, OP_SRLI:   nxt_val = s1_a >> s1_b[4:0];
            OP_SRA, OP_SRAI:   nxt_val = $unsigned($signed(s1_a) >>> s1_b[4:0]);
            OP_SLT, OP_SLTI:   nxt_val = {{(DATA_W-1){1'b0}}, lt_s};
            OP_SLTU, OP_SLTIU: nxt_val = {{(DATA_W-1){1'b0}}, lt_u};
            OP_AND, OP_ANDI:   nxt_val = s1_a & s1_b;
            OP_OR, OP_ORI:     nxt_val = s1_a | s1_b;
            OP_XOR, OP_XORI:   nxt_val = s1_a ^ s1_b;
            OP_LUI:            nxt_val = s1_imm;
            OP_AUIPC:          nxt_val = br_target;
            OP_JAL: begin
                nxt_val  = pc4;
                nxt_jump = 1'b1;
                nxt_pc   = br_target;
            end
            OP_JALR: begin
                nxt_val  = pc4;
                nxt_jump = 1'b1;
                nxt_pc   = {sum[DATA_W-1:1], 1'b0};
            end
            OP_BEQ:  begin is_branch = 1'b1; br_taken = eq;    end
            OP_BNE:  begin is_branch = 1'b1; br_taken = !eq;   end
            OP_BLT:  begin is_branch = 1'b1; br_taken = lt_s;  end
            OP_BGE:  begin is_branch = 1'b1; br_taken = !lt_s; end
            OP_BLTU: begin is_branch = 1'b1; br_taken = lt_u;  end
            OP_BGEU: begin is_branch = 1'b1; br_taken = !lt_u; end
            default: nxt_val = '0;
        endcase
        if (is_branch && br_taken) begin
            nxt_jump = 1'b1;
            nxt_pc   = br_target;
        end
    end

    // A broadcast visible during a rollback cycle is still consumed, so it is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld     <= 1'b0;
            s2_rob     <= '0;
            s2_val     <= '0;
            s2_jump    <= 1'b0;
            s2_pc      <= '0;
            op_count   <= '0;
            jump_count <= '0;
        end else begin
            if (rdy && s2_vld) begin
                op_count <= op_count + 32'd1;
                if (s2_jump) jump_count <= jump_count + 32'd1;
            end
            if (rollback) begin
                s2_vld <= 1'b0;
            end else if (rdy) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_rob  <= s1_rob;
                    s2_val  <= nxt_val;
                    s2_jump <= nxt_jump;
                    s2_pc   <= nxt_pc;
                end
            end
        end
    end

    assign alu.alu_result_ready   = s2_vld;
    assign alu.alu_result_rob_pos = s2_rob;
    assign alu.alu_result_val     = s2_val;
    assign alu.alu_result_jump    = s2_jump;
    assign alu.alu_result_pc      = s2_pc;
endmodule

// File: tb/tb_alu_exec.sv
// Directed and randomized checks of alu_exec against an arithmetic reference model.
module tb_alu_exec;
    localparam logic [5:0] LUI = 1, AUIPC = 2, JAL = 3, JALR = 4, BEQ = 5, BNE = 6,
        BLT = 7, BGE = 8, BLTU = 9, BGEU = 10, ADDI = 19, SLTI = 20, SLTIU = 21,
        XORI = 22, ORI = 23, ANDI = 24, SLLI = 25, SRLI = 26, SRAI = 27, ADD = 28,
        SUB = 29, SLL = 30, SLT = 31, SLTU = 32, XOR = 33, SRL = 34, SRA = 35,
        OR_ = 36, AND_ = 37;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic [31:0] op_count, jump_count;
    int          checks = 0;
    int          failures = 0;

    alu_exec_if #(.OP_W(6), .ROB_POS_W(5), .DATA_W(32)) bus ();

    alu_exec #(.OP_W(6), .ROB_POS_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .alu(bus), .op_count(op_count), .jump_count(jump_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
        bus.alu_enable  = 1'b1;
        bus.alu_openum  = op;
        bus.alu_rs1_val = rs1;
        bus.alu_rs2_val = rs2;
        bus.alu_imm     = imm;
        bus.alu_pc      = pc;
        bus.alu_rob_pos = tag;
    endtask

    task automatic idle();
        bus.alu_enable = 1'b0;
    endtask

    // Reference semantics straight from the RV32I rules.
    function automatic void model(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [31:0] pc,
                                  output logic [31:0] val, output logic jump, output logic [31:0] npc);
        logic take;
        take = 1'b0;
        val  = 32'd0;
        jump = 1'b0;
        npc  = pc + 32'd4;
        case (op)
            ADD:   val = rs1 + rs2;
            ADDI:  val = rs1 + imm;
            SUB:   val = rs1 - rs2;
            SLL:   val = rs1 << rs2[4:0];
            SLLI:  val = rs1 << imm[4:0];
            SRL:   val = rs1 >> rs2[4:0];
            SRLI:  val = rs1 >> imm[4:0];
            SRA:   val = $unsigned($signed(rs1) >>> rs2[4:0]);
            SRAI:  val = $unsigned($signed(rs1) >>> imm[4:0]);
            SLT:   val = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
            SLTI:  val = ($signed(rs1) < $signed(imm)) ? 32'd1 : 32'd0;
            SLTU:  val = (rs1 < rs2) ? 32'd1 : 32'd0;
            SLTIU: val = (rs1 < imm) ? 32'd1 : 32'd0;
            AND_:  val = rs1 & rs2;
            ANDI:  val = rs1 & imm;
            OR_:   val = rs1 | rs2;
            ORI:   val = rs1 | imm;
            XOR:   val = rs1 ^ rs2;
            XORI:  val = rs1 ^ imm;
            LUI:   val = imm;
            AUIPC: val = pc + imm;
            JAL:   begin val = pc + 32'd4; jump = 1'b1; npc = pc + imm; end
            JALR:  begin val = pc + 32'd4; jump = 1'b1; npc = (rs1 + imm) & 32'hFFFF_FFFE; end
            BEQ:   take = (rs1 == rs2);
            BNE:   take = (rs1 != rs2);
            BLT:   take = ($signed(rs1) < $signed(rs2));
            BGE:   take = ($signed(rs1) >= $signed(rs2));
            BLTU:  take = (rs1 < rs2);
            BGEU:  take = (rs1 >= rs2);
            default: val = 32'd0;
        endcase
        if (take) begin
            jump = 1'b1;
            npc  = pc + imm;
        end
    endfunction

    logic [5:0] op_tbl [30] = '{LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, ADDI,
        SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL,
        SRA, OR_, AND_, 6'd50};

    initial begin
        logic [5:0]  op;
        logic [31:0] rs1, rs2, imm, pc, val, npc;
        logic        jump;
        logic [4:0]  tag;
        int          n_ops, n_jumps, t;
        exp_t        e;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        issue(ADD, 0, 0, 0, 0, 1); idle();
        tick(); tick();
        chk("rst_ready", {31'd0, bus.alu_result_ready}, 0);
        chk("rst_rob", {27'd0, bus.alu_result_rob_pos}, 0);
        chk("rst_val", bus.alu_result_val, 0);
        chk("rst_jump", {31'd0, bus.alu_result_jump}, 0);
        chk("rst_pc", bus.alu_result_pc, 0);
        chk("rst_opcnt", op_count, 0);
        chk("rst_jmpcnt", jump_count, 0);
        rst = 1'b0;

        // ADDI latency
        issue(ADDI, 5, 0, 32'hFFFF_FFFD, 32'h40, 3); tick(); idle();
        chk("addi_c1_ready", {31'd0, bus.alu_result_ready}, 0);
        tick();
        chk("addi_ready", {31'd0, bus.alu_result_ready}, 1);
        chk("addi_rob", {27'd0, bus.alu_result_rob_pos}, 3);
        chk("addi_val", bus.alu_result_val, 2);
        chk("addi_jump", {31'd0, bus.alu_result_jump}, 0);
        chk("addi_pc", bus.alu_result_pc, 32'h44);
        tick();
        chk("addi_c3_ready", {31'd0, bus.alu_result_ready}, 0);
        chk("addi_opcnt", op_count, 1);

        // back-to-back shifts and compares
        issue(SRA, 32'h8000_0000, 32'h24, 0, 32'h80, 4); tick();
        issue(SLTU, 1, 32'hFFFF_FFFF, 0, 32'h84, 5); tick();
        issue(SLT, 1, 32'hFFFF_FFFF, 0, 32'h88, 6);
        chk("sra_ready", {31'd0, bus.alu_result_ready}, 1);
        chk("sra_val", bus.alu_result_val, 32'hF800_0000);
        chk("sra_rob", {27'd0, bus.alu_result_rob_pos}, 4);
        tick(); idle();
        chk("sltu_ready", {31'd0, bus.alu_result_ready}, 1);
        chk("sltu_val", bus.alu_result_val, 1);
        tick();
        chk("slt_ready", {31'd0, bus.alu_result_ready}, 1);
        chk("slt_val", bus.alu_result_val, 0);
        chk("slt_rob", {27'd0, bus.alu_result_rob_pos}, 6);
        tick();
        chk("b2b_opcnt", op_count, 4);

        // branches
        issue(BNE, 7, 7, 32'h20, 32'h100, 7); tick();
        issue(BLT, 32'hFFFF_FFFF, 0, 32'h20, 32'h100, 8); tick(); idle();
        chk("bne_jump", {31'd0, bus.alu_result_jump}, 0);
        chk("bne_pc", bus.alu_result_pc, 32'h104);
        chk("bne_val", bus.alu_result_val, 0);
        tick();
        chk("blt_jump", {31'd0, bus.alu_result_jump}, 1);
        chk("blt_pc", bus.alu_result_pc, 32'h120);
        tick();
        chk("blt_jmpcnt", jump_count, 1);

        // JALR clears bit 0 of the target
        issue(JALR, 32'h1003, 0, 4, 32'h200, 9); tick(); idle(); tick();
        chk("jalr_val", bus.alu_result_val, 32'h204);
        chk("jalr_jump", {31'd0, bus.alu_result_jump}, 1);
        chk("jalr_pc", bus.alu_result_pc, 32'h1006);
        tick();
        chk("jalr_opcnt", op_count, 7);
        chk("jalr_jmpcnt", jump_count, 2);

        // rollback flushes both in-flight ops
        issue(ADD, 1, 2, 0, 32'h300, 10); tick();
        issue(ADD, 3, 4, 0, 32'h304, 11); rollback = 1'b1; tick();
        idle(); rollback = 1'b0;
        chk("rb_c2_ready", {31'd0, bus.alu_result_ready}, 0);
        tick();
        chk("rb_c3_ready", {31'd0, bus.alu_result_ready}, 0);
        tick();
        chk("rb_opcnt", op_count, 7);

        // rdy low freezes the pipe
        issue(XORI, 32'hF0F0, 0, 32'h0FF0, 32'h400, 12); tick();
        idle(); rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", {31'd0, bus.alu_result_ready}, 0);
        end
        rdy = 1'b1; tick();
        chk("stall_rel_ready", {31'd0, bus.alu_result_ready}, 1);
        chk("stall_rel_val", bus.alu_result_val, 32'hFF00);
        chk("stall_rel_rob", {27'd0, bus.alu_result_rob_pos}, 12);
        tick();
        chk("stall_opcnt", op_count, 8);

        // randomized traffic against the model, from a clean reset
        rst = 1'b1; tick(); rst = 1'b0;
        n_ops = 0; n_jumps = 0;
        t = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc < 396 && $urandom_range(0, 3) != 0) begin
                op  = op_tbl[$urandom_range(0, 29)];
                rs1 = $urandom;
                rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
                imm = $urandom;
                pc  = $urandom & 32'hFFFF_FFFC;
                tag = 5'($urandom_range(1, 31));
                model(op, rs1, rs2, imm, pc, val, jump, npc);
                e.due = t + 2; e.rob = tag; e.val = val; e.jump = jump; e.pc = npc;
                q.push_back(e);
                n_ops++;
                if (jump) n_jumps++;
                issue(op, rs1, rs2, imm, pc, tag);
            end else begin
                idle();
            end
            tick();
            t++;
            if (q.size() > 0 && q[0].due == t) begin
                e = q.pop_front();
                chk("rnd_ready", {31'd0, bus.alu_result_ready}, 1);
                chk("rnd_rob", {27'd0, bus.alu_result_rob_pos}, {27'd0, e.rob});
                chk("rnd_val", bus.alu_result_val, e.val);
                chk("rnd_jump", {31'd0, bus.alu_result_jump}, {31'd0, e.jump});
                chk("rnd_pc", bus.alu_result_pc, e.pc);
            end else begin
                chk("rnd_idle", {31'd0, bus.alu_result_ready}, 0);
            end
        end
        chk("rnd_drained", q.size(), 0);
        chk("rnd_opcnt", op_count, n_ops);
        chk("rnd_jmpcnt", jump_count, n_jumps);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
# alu_exec

Two-stage pipelined integer execute unit. It is the consumer end of the reservation-station issue interface and the producer of the ALU result broadcast that the RS, LSB and ROB snoop. It accepts at most one RV32I non-memory operation per cycle, computes the result and any branch/jump outcome, and broadcasts it two cycles later. It keeps retired-op and taken-jump counters.

## Interface
Parameters:
- OP_W, 6: width of `OPENUM_TYPE`.
- ROB_POS_W, 5: width of `ROB_WRAP_POS_TYPE`. Value 0 is reserved to mean "no tag".
- DATA_W, 32: data and address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- rdy  in  1  global enable. When low, all state holds.
- rollback  in  1  flush. Synchronous, same effect as rst except that the counters keep their values.
- alu_enable  in  1  operation valid this cycle.
- alu_openum  in  OP_W  operation, encoded with the `OPENUM_*` constants from definition.v.
- alu_rob_pos  in  ROB_POS_W  destination ROB tag. Never 0 when alu_enable is high.
- alu_rs1_val, alu_rs2_val, alu_imm  in  DATA_W  operands.
- alu_pc  in  DATA_W  instruction PC.
- alu_result_ready  out  1  broadcast valid. High for exactly one cycle per accepted op.
- alu_result_rob_pos  out  ROB_POS_W  tag of the result.
- alu_result_val  out  DATA_W  value written to rd.
- alu_result_jump  out  1  control transfer taken.
- alu_result_pc  out  DATA_W  next PC: target if taken, pc+4 otherwise.
- op_count  out  32  number of ops broadcast, wraps.
- jump_count  out  32  number of broadcasts with jump=1, wraps.

## Operation
- No backpressure: every alu_enable=1 with rdy=1 is accepted.
- S1 (register stage 1):
  - Latch valid, openum, rob_pos and pc.
  - Latch A = rs1. Latch B = imm for OP-IMM, LUI, AUIPC, JAL and JALR; B = rs2 for OP and branches.
  - Latch imm separately for branch and jump targets.
- S2 (register stage 2): compute and register the result, then drive the outputs.
- Result rules:
  - ADD/ADDI: A+B, mod 2^32. SUB: A-B.
  - SLL/SRL/SRA and the immediate forms: shift amount = B[4:0].
  - SLT/SLTI: signed compare, result 1 or 0. SLTU/SLTIU: unsigned compare.
  - AND/OR/XOR and the immediate forms: bitwise.
  - LUI: imm. AUIPC: pc+imm.
  - JAL: val = pc+4, jump=1, target pc+imm.
  - JALR: val = pc+4, jump=1, target (rs1+imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: val = 0. Taken iff the condition holds on (rs1, rs2), with signed compare for BLT/BGE. Target pc+imm.
  - Non-jump ops: jump=0, alu_result_pc = pc+4.
- Unknown openum: broadcast anyway with val=0, jump=0, pc=pc+4, so the ROB never hangs.
- Counters:
  - op_count increments on every cycle with alu_result_ready=1.
  - jump_count increments additionally when alu_result_jump=1.
  - Both are cleared only by rst.

## Timing
- Reset values, after rst=1 at a clock edge:
  - alu_result_ready=0, alu_result_rob_pos=0, alu_result_val=0, alu_result_jump=0, alu_result_pc=0.
  - op_count=0, jump_count=0.
  - Both stage valids = 0.
- Latency: op sampled at edge N (alu_enable high in cycle N) has its broadcast visible during cycle N+2. Throughput is 1 op/cycle.
- rollback sampled at edge N:
  - Both valids clear. alu_result_ready=0 in cycle N+1.
  - An op presented with alu_enable in the same cycle as rollback is dropped.
  - A broadcast already visible in cycle N is still consumed normally in cycle N.
- rdy=0: S1, S2, outputs and counters hold. alu_result_ready stays at its value; consumers gate it with rdy themselves.
- rst has priority over rollback, which has priority over rdy.
- Back-to-back ops emit back-to-back broadcasts in issue order. There is no reordering and no bubble.

## Test plan
- Reset, then ADDI rs1=5 imm=-3 tag 3 at cycle 0 -> cycle 2: ready=1, rob_pos=3, val=2, jump=0, pc=issue pc+4. Cycle 3: ready=0, op_count=1.
- SRA rs1=0x80000000 rs2=0x24; then SLTU rs1=1 rs2=0xFFFFFFFF; then SLT on the same operands -> consecutive broadcasts in order:
  - 0xF8000000 (shift amount 4),
  - 1,
  - 0.
- BNE rs1=rs2=7, pc=0x100, imm=0x20 -> jump=0, pc=0x104. BLT rs1=-1 rs2=0, same pc and imm -> jump=1, pc=0x120, jump_count=1.
- JALR rs1=0x1003 imm=4 pc=0x200 -> val=0x204, jump=1, pc=0x1006.
- Issue ops in cycles 0 and 1, rollback in cycle 1 -> the cycle-0 op broadcasts in cycle 2? No: it is flushed and no broadcast occurs in cycles 2-3. op_count is unchanged.
- Issue in cycle 0 and hold rdy=0 in cycles 1-3 -> no progress. The broadcast appears in cycle 5 once rdy=1 from cycle 4.
